// File: rtl/serial_tsi_pkg.sv
// Shared definitions for the serial TSI adapter: word width, command codes and
// the protocol FSM state encoding.
package serial_tsi_pkg;

  localparam int TSI_WORD_W = 32;

  localparam logic [TSI_WORD_W-1:0] TSI_CMD_READ  = 32'd0;
  localparam logic [TSI_WORD_W-1:0] TSI_CMD_WRITE = 32'd1;

  typedef enum logic [3:0] {
    S_CMD,
    S_ADDR_LO,
    S_ADDR_HI,
    S_LEN_LO,
    S_LEN_HI,
    S_WDATA,
    S_WREQ,
    S_WRESP,
    S_RREQ,
    S_RRESP,
    S_RDATA
  } tsi_state_e;

endpackage

// File: rtl/serial_tsi_adapter.sv
// Turns the host->target TSI word stream into single-outstanding, word-granular
// memory requests and streams read data back to the host.
module serial_tsi_adapter
  import serial_tsi_pkg::*;
#(
  parameter int MEM_ADDR_W = 32,
  parameter int LEN_W      = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  serial_in_valid,
  output logic                  serial_in_ready,
  input  logic [TSI_WORD_W-1:0] serial_in_bits,
  output logic                  serial_out_valid,
  input  logic                  serial_out_ready,
  output logic [TSI_WORD_W-1:0] serial_out_bits,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [MEM_ADDR_W-1:0] mem_req_addr,
  output logic                  mem_req_we,
  output logic [TSI_WORD_W-1:0] mem_req_wdata,
  input  logic                  mem_resp_valid,
  output logic                  mem_resp_ready,
  input  logic [TSI_WORD_W-1:0] mem_resp_rdata,
  output logic                  bad_cmd
);

  tsi_state_e            state_q, state_d;
  logic [MEM_ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [TSI_WORD_W-1:0] wdata_q, wdata_d;
  logic [TSI_WORD_W-1:0] rdata_q, rdata_d;
  logic                  bad_q, bad_d;
  logic                  in_rdy_q, in_rdy_d;
  logic                  beat_done;
  logic                  last_beat;

  assign last_beat = (cnt_q == '0);

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    bad_d     = 1'b0;
    beat_done = 1'b0;

    unique case (state_q)
      S_CMD: if (serial_in_valid) begin
        if (serial_in_bits == TSI_CMD_READ) begin
          we_d    = 1'b0;
          state_d = S_ADDR_LO;
        end else if (serial_in_bits == TSI_CMD_WRITE) begin
          we_d    = 1'b1;
          state_d = S_ADDR_LO;
        end else begin
          bad_d = 1'b1;
        end
      end
      S_ADDR_LO: if (serial_in_valid) begin
        addr_d  = MEM_ADDR_W'(serial_in_bits);
        state_d = S_ADDR_HI;
      end
      // Low word parked in addr_q is merged with the high word, then word-aligned.
      S_ADDR_HI: if (serial_in_valid) begin
        addr_d  = MEM_ADDR_W'({serial_in_bits, TSI_WORD_W'(addr_q)}) & ~MEM_ADDR_W'(3);
        state_d = S_LEN_LO;
      end
      S_LEN_LO: if (serial_in_valid) begin
        cnt_d   = LEN_W'(serial_in_bits);
        state_d = S_LEN_HI;
      end
      S_LEN_HI: if (serial_in_valid) state_d = we_q ? S_WDATA : S_RREQ;
      S_WDATA: if (serial_in_valid) begin
        wdata_d = serial_in_bits;
        state_d = S_WREQ;
      end
      S_WREQ:  if (mem_req_ready) state_d = S_WRESP;
      S_WRESP: if (mem_resp_valid) begin
        beat_done = 1'b1;
        state_d   = last_beat ? S_CMD : S_WDATA;
      end
      S_RREQ:  if (mem_req_ready) state_d = S_RRESP;
      S_RRESP: if (mem_resp_valid) begin
        rdata_d = mem_resp_rdata;
        state_d = S_RDATA;
      end
      S_RDATA: if (serial_out_ready) begin
        beat_done = 1'b1;
        state_d   = last_beat ? S_CMD : S_RREQ;
      end
      default: state_d = S_CMD;
    endcase

    if (beat_done) begin
      addr_d = addr_q + MEM_ADDR_W'(4);
      cnt_d  = cnt_q - LEN_W'(1);
    end

    // Registered so ready is low while reset is held yet tracks the state.
    in_rdy_d = state_d inside {S_CMD, S_ADDR_LO, S_ADDR_HI, S_LEN_LO, S_LEN_HI, S_WDATA};
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q  <= S_CMD;
      addr_q   <= '0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      bad_q    <= 1'b0;
      in_rdy_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      bad_q    <= bad_d;
      in_rdy_q <= in_rdy_d;
    end
  end

  assign serial_in_ready  = in_rdy_q;
  assign serial_out_valid = (state_q == S_RDATA);
  assign serial_out_bits  = rdata_q;
  assign mem_req_valid    = (state_q == S_WREQ) || (state_q == S_RREQ);
  assign mem_req_addr     = addr_q;
  assign mem_req_we       = we_q;
  assign mem_req_wdata    = wdata_q;
  assign mem_resp_ready   = (state_q == S_WRESP) || (state_q == S_RRESP);
  assign bad_cmd          = bad_q;

endmodule

// File: tb/tb_serial_tsi_adapter.sv
// Self-checking bench for serial_tsi_adapter: a host driver, a memory responder
// and a transaction-level reference memory predict every request and read word.
module tb_serial_tsi_adapter;
  import serial_tsi_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        serial_in_valid, serial_in_ready;
  logic [31:0] serial_in_bits;
  logic        serial_out_valid, serial_out_ready;
  logic [31:0] serial_out_bits;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_we;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid, mem_resp_ready;
  logic [31:0] mem_resp_rdata;
  logic        bad_cmd;

  serial_tsi_adapter #(.MEM_ADDR_W(32), .LEN_W(32)) dut (
    .clock(clock), .reset(reset),
    .serial_in_valid(serial_in_valid), .serial_in_ready(serial_in_ready),
    .serial_in_bits(serial_in_bits),
    .serial_out_valid(serial_out_valid), .serial_out_ready(serial_out_ready),
    .serial_out_bits(serial_out_bits),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_resp_rdata(mem_resp_rdata), .bad_cmd(bad_cmd)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } req_t;

  req_t        req_q[$];
  logic [31:0] dev_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int          errors = 0;
  int          checks = 0;
  bit          resp_hold = 0;
  bit          rnd_mem = 0;
  int          out_valid_cycles = 0;
  int          bad_pulses = 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial forever begin
    @(negedge clock);
    if (serial_out_valid) out_valid_cycles++;
    if (bad_cmd) bad_pulses++;
  end

  // Memory responder: one response the cycle after each accepted request.
  initial begin
    bit          req_hs, resp_hs, held_v, pend_we;
    logic [31:0] pend_addr;
    req_t        held;
    req_hs = 0; resp_hs = 0; held_v = 0; pend_we = 0; pend_addr = '0; held = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        req_hs = 0; resp_hs = 0; held_v = 0;
        mem_resp_valid = 1'b0; mem_req_ready = 1'b0;
        continue;
      end
      if (resp_hs) begin mem_resp_valid = 1'b0; resp_hs = 0; end
      if (req_hs && !resp_hold) begin
        mem_resp_valid = 1'b1;
        if (pend_we) mem_resp_rdata = $urandom;
        else mem_resp_rdata = dev_mem.exists(pend_addr) ? dev_mem[pend_addr] : (32'hBAD0_0000 ^ pend_addr);
        req_hs = 0;
      end
      if (held_v) begin
        checks++;
        if (!mem_req_valid || {mem_req_addr, mem_req_we, mem_req_wdata} !== held) begin
          errors++;
          $display("FAIL mem_req_stable: got valid=%0b addr=%h we=%0b wdata=%h, required addr=%h we=%0b wdata=%h",
                   mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, held.addr, held.we, held.wdata);
        end
      end
      held_v = 0;
      mem_req_ready = rnd_mem ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mem_req_valid) begin
        if (mem_req_ready) begin
          req_hs = 1; pend_addr = mem_req_addr; pend_we = mem_req_we;
          req_q.push_back('{mem_req_addr, mem_req_we, mem_req_wdata});
          if (mem_req_we) dev_mem[mem_req_addr] = mem_req_wdata;
        end else begin
          held_v = 1; held = '{mem_req_addr, mem_req_we, mem_req_wdata};
        end
      end
      if (mem_resp_valid) begin
        if (!mem_resp_ready) begin
          errors++; checks++;
          $display("FAIL mem_resp_protocol: response offered with mem_resp_ready=%0b, required 1", mem_resp_ready);
        end else resp_hs = 1;
      end
    end
  end

  task automatic idle_gap(input bit gaps);
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clock);
  endtask

  task automatic send_word(input logic [31:0] w);
    int n = 0;
    serial_in_valid = 1'b1;
    serial_in_bits  = w;
    while (!serial_in_ready && n < 300) begin @(negedge clock); n++; end
    if (!serial_in_ready) begin
      errors++; checks++;
      $display("FAIL send_timeout: serial_in_ready=%0b after %0d cycles, required 1", serial_in_ready, n);
    end
    @(negedge clock);
    serial_in_valid = 1'b0;
    serial_in_bits  = $urandom;
  endtask

  task automatic recv_word(output logic [31:0] w, input bit rnd);
    int          n = 0;
    bit          got = 0, held = 0;
    logic [31:0] hb = '0;
    w = '0;
    while (!got && n < 500) begin
      serial_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (held) begin
        checks++;
        if (!serial_out_valid || serial_out_bits !== hb) begin
          errors++;
          $display("FAIL serial_out_stable: got valid=%0b bits=%h, required valid=1 bits=%h",
                   serial_out_valid, serial_out_bits, hb);
        end
      end
      held = 0;
      if (serial_out_valid) begin
        if (serial_out_ready) begin w = serial_out_bits; got = 1; end
        else begin held = 1; hb = serial_out_bits; end
      end
      @(negedge clock);
      n++;
    end
    serial_out_ready = 1'b0;
    if (!got) begin
      errors++; checks++;
      $display("FAIL recv_timeout: no serial_out word after %0d cycles, required one", n);
    end
  endtask

  task automatic send_header(input logic [31:0] cmd, input logic [63:0] a,
                             input logic [31:0] len_lo, input bit gaps);
    idle_gap(gaps); send_word(cmd);
    idle_gap(gaps); send_word(a[31:0]);
    idle_gap(gaps); send_word(a[63:32]);
    idle_gap(gaps); send_word(len_lo);
    idle_gap(gaps); send_word($urandom);
  endtask

  task automatic do_write(input logic [63:0] a, input int nbeats, input bit rnd, input string tag);
    logic [31:0] data[$];
    logic [31:0] base = a[31:0] & ~32'h3;
    logic [31:0] ea;
    int          start_out = out_valid_cycles;
    int          n = 0;
    rnd_mem = rnd;
    req_q.delete();
    send_header(TSI_CMD_WRITE, a, 32'(nbeats - 1), rnd);
    for (int i = 0; i < nbeats; i++) begin
      data.push_back($urandom);
      idle_gap(rnd);
      send_word(data[i]);
    end
    while (!(req_q.size() >= nbeats && serial_in_ready) && n < 200) begin @(negedge clock); n++; end
    checks++;
    if (req_q.size() != nbeats || !serial_in_ready) begin
      errors++;
      $display("FAIL %s_done: requests=%0d ready=%0b, required requests=%0d ready=1",
               tag, req_q.size(), serial_in_ready, nbeats);
    end
    for (int i = 0; i < nbeats; i++) begin
      ea = base + 32'(4 * i);
      ref_mem[ea] = data[i];
      checks++;
      if (i >= req_q.size() || req_q[i] !== req_t'{ea, 1'b1, data[i]}) begin
        errors++;
        $display("FAIL %s_req%0d: got %h, required addr=%h we=1 wdata=%h",
                 tag, i, (i < req_q.size()) ? req_q[i] : req_t'('x), ea, data[i]);
      end
    end
    checks++;
    if (out_valid_cycles != start_out) begin
      errors++;
      $display("FAIL %s_no_out: serial_out_valid seen %0d cycles, required 0", tag, out_valid_cycles - start_out);
    end
    rnd_mem = 0;
  endtask

  task automatic do_read(input logic [63:0] a, input int nbeats, input bit rnd, input string tag);
    logic [31:0] base = a[31:0] & ~32'h3;
    logic [31:0] ea, w, v;
    for (int i = 0; i < nbeats; i++) begin
      ea = base + 32'(4 * i);
      if (!ref_mem.exists(ea)) begin v = $urandom; ref_mem[ea] = v; dev_mem[ea] = v; end
    end
    rnd_mem = rnd;
    req_q.delete();
    send_header(TSI_CMD_READ, a, 32'(nbeats - 1), rnd);
    for (int i = 0; i < nbeats; i++) begin
      ea = base + 32'(4 * i);
      recv_word(w, rnd);
      checks++;
      if (w !== ref_mem[ea]) begin
        errors++;
        $display("FAIL %s_word%0d: got %h, required %h", tag, i, w, ref_mem[ea]);
      end
    end
    checks++;
    if (serial_in_ready !== 1'b1 || serial_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: ready=%0b out_valid=%0b, required ready=1 out_valid=0",
               tag, serial_in_ready, serial_out_valid);
    end
    for (int i = 0; i < nbeats; i++) begin
      ea = base + 32'(4 * i);
      checks++;
      if (i >= req_q.size() || req_q[i].addr !== ea || req_q[i].we !== 1'b0) begin
        errors++;
        $display("FAIL %s_rreq%0d: got %h, required addr=%h we=0",
                 tag, i, (i < req_q.size()) ? req_q[i] : req_t'('x), ea);
      end
    end
    rnd_mem = 0;
  endtask

  task automatic preload(input logic [31:0] ea, input logic [31:0] v);
    ref_mem[ea] = v;
    dev_mem[ea] = v;
  endtask

  task automatic check_reset_outputs(input string tag);
    logic [101:0] v;
    v = {serial_in_ready, serial_out_valid, mem_req_valid, mem_resp_ready, bad_cmd,
         serial_out_bits, mem_req_addr, mem_req_we, mem_req_wdata};
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL %s: outputs=%h, required all zero", tag, v);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset_values");
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (serial_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: serial_in_ready=%0b, required 1", serial_in_ready);
    end
  endtask

  task automatic test_write_basic;
    do_write(64'h0000_0000_8000_0000, 2, 1'b0, "write_basic");
  endtask

  task automatic test_read_basic;
    preload(32'h8000_0000, 32'h0000_000A);
    preload(32'h8000_0004, 32'h0000_000B);
    do_read(64'h0000_0000_8000_0000, 2, 1'b0, "read_basic");
  endtask

  task automatic test_bad_cmd;
    int start = bad_pulses;
    send_word(32'h7);
    checks++;
    if (bad_cmd !== 1'b1 || serial_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bad_cmd_pulse: bad_cmd=%0b ready=%0b, required 1 and 1", bad_cmd, serial_in_ready);
    end
    do_read(64'h0000_0000_2000_0100, 1, 1'b0, "bad_cmd_read");
    checks++;
    if (bad_pulses - start != 1) begin
      errors++;
      $display("FAIL bad_cmd_count: pulses=%0d, required 1", bad_pulses - start);
    end
  endtask

  task automatic test_read_stall;
    do_read(64'h0000_0000_4000_0010, 4, 1'b1, "read_stall");
  endtask

  task automatic test_addr_wrap;
    do_write(64'h0000_0001_FFFF_FFFD, 2, 1'b0, "addr_wrap");
  endtask

  task automatic test_reset_mid_write;
    int n = 0;
    req_q.delete();
    resp_hold = 1;
    send_header(TSI_CMD_WRITE, 64'h0000_0000_0000_1000, 32'd3, 1'b0);
    send_word(32'hCAFE_0001);
    while (mem_resp_ready !== 1'b1 && n < 50) begin @(negedge clock); n++; end
    checks++;
    if (mem_resp_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_wresp: mem_resp_ready=%0b, required 1", mem_resp_ready);
    end
    reset = 1'b1;
    @(negedge clock);
    check_reset_outputs("midreset_values");
    resp_hold = 0;
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (serial_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ready: serial_in_ready=%0b, required 1", serial_in_ready);
    end
    do_read(64'h0000_0000_0000_1000, 2, 1'b0, "midreset_read");
  endtask

  task automatic test_random;
    logic [63:0] a;
    for (int t = 0; t < 8; t++) begin
      a = {32'($urandom), 20'h0, 12'($urandom_range(0, 63))};
      if ($urandom_range(0, 1) != 0) do_write(a, $urandom_range(1, 4), 1'b1, "rand_write");
      else do_read(a, $urandom_range(1, 4), 1'b1, "rand_read");
    end
  endtask

  initial begin
    serial_in_valid  = 1'b0;
    serial_in_bits   = '0;
    serial_out_ready = 1'b0;
    test_reset();
    test_write_basic();
    test_read_basic();
    test_bad_cmd();
    test_read_stall();
    test_addr_wrap();
    test_reset_mid_write();
    test_random();
    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_tsi_adapter.md
# serial_tsi_adapter

Consumes the 32-bit host→target word stream produced by the simulation serial link and turns it into word-granular memory requests on a single-outstanding request/response port. Read data returns as a 32-bit target→host word stream. It sits directly downstream of the serial link model's `serial_in_*` outputs and directly upstream of its `serial_out_*` inputs, in front of the memory/bus bridge.

## Interface
- `MEM_ADDR_W`, default 32: width of the memory address. The protocol's 64-bit address is truncated to this width.
- `LEN_W`, default 32: width of the beat counter. Only the low length word is used.
- `clock`, in, 1: sole clock; all logic on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `serial_in_valid`, in, 1: host word valid.
- `serial_in_ready`, out, 1: adapter accepts a host word.
- `serial_in_bits`, in, 32: host word.
- `serial_out_valid`, out, 1: read-data word valid.
- `serial_out_ready`, in, 1: host accepts the read-data word.
- `serial_out_bits`, out, 32: read-data word.
- `mem_req_valid`, out, 1: memory request valid.
- `mem_req_ready`, in, 1: memory accepts the request.
- `mem_req_addr`, out, MEM_ADDR_W: byte address, always 4-aligned.
- `mem_req_we`, out, 1: 1 = write, 0 = read.
- `mem_req_wdata`, out, 32: write data.
- `mem_resp_valid`, in, 1: response valid, one per request (write ack or read data).
- `mem_resp_ready`, out, 1: adapter accepts the response.
- `mem_resp_rdata`, in, 32: read data, ignored for writes.
- `bad_cmd`, out, 1: one-cycle pulse when an unknown command word is consumed.

## Operation
- Protocol: the first word is `cmd` (0 = READ, 1 = WRITE). It is followed by `addr_lo`, `addr_hi`, `len_lo`, `len_hi`. Beats = `len_lo` + 1.
- After the header, a WRITE carries beats × data words. A READ returns beats × words on `serial_out` and nothing else.
- A WRITE produces no host-visible acknowledgement.
- Address: the adapter stores `{addr_hi, addr_lo}[MEM_ADDR_W-1:0]` with bits [1:0] forced to 0. The address increments by 4 per beat and wraps modulo 2^MEM_ADDR_W.
- `len_hi` is consumed and discarded.
- Beat counter: loaded with `len_lo[LEN_W-1:0]` and decremented per completed beat. The transaction ends on the beat where the counter equals 0.
- FSM states and transitions:
  - S_CMD → S_ADDR_LO on a valid cmd. A cmd word > 1 is consumed, pulses `bad_cmd` the next cycle, and the FSM stays in S_CMD.
  - S_ADDR_LO → S_ADDR_HI → S_LEN_LO → S_LEN_HI, each on a `serial_in` handshake.
  - S_LEN_HI → S_WDATA (write) or S_RREQ (read).
  - Write loop: S_WDATA (accept a word into the wdata register) → S_WREQ (`mem_req_valid`, we = 1) → S_WRESP (`mem_resp_ready`). On the response, the FSM goes to S_CMD if this was the last beat, else back to S_WDATA.
  - Read loop: S_RREQ (we = 0) → S_RRESP (capture rdata) → S_RDATA (`serial_out_valid`). On the `serial_out` handshake, the FSM goes to S_CMD if this was the last beat, else back to S_RREQ.
- `serial_in_ready` = 1 only in S_CMD, the four header states, and S_WDATA.
- `mem_resp_ready` = 1 only in S_WRESP and S_RRESP. A response arriving in any other state is a protocol violation; the bench asserts it never happens.
- At most one memory request is outstanding.

## Timing
- Reset values: `serial_in_ready` = 0, `serial_out_valid` = 0, `mem_req_valid` = 0, `mem_resp_ready` = 0, `bad_cmd` = 0, `serial_out_bits` = 0, `mem_req_addr` = 0, `mem_req_we` = 0, `mem_req_wdata` = 0. State = S_CMD.
- `serial_in_ready` = 1 in the first cycle after reset deasserts.
- All outputs are decoded from registered state and registers. There is no combinational path from any input to any output.
- Header: 5 cycles minimum, one word per cycle under back-to-back valid.
- Write beat: 3 cycles minimum (WDATA, WREQ, WRESP) with zero-wait memory.
- Read beat: 3 cycles minimum (RREQ, RRESP, RDATA) with zero-wait memory and host.
- Valid/ready rules:
  - `mem_req_*` and `serial_out_*` hold stable while valid && !ready.
  - Valid never drops before the handshake.
- Reset mid-transaction: the FSM abandons the transaction immediately and returns to S_CMD. A response for the abandoned request is not tracked; the system resets the memory side together with the adapter.
- Counter wrap: `len_lo` = 0xFFFF_FFFF with LEN_W = 32 gives 2^32 beats. No overflow special case is needed.

## Structure
- Package `serial_tsi_pkg` holds:
  - the state enum `tsi_state_e`;
  - `TSI_CMD_READ` = 32'd0 and `TSI_CMD_WRITE` = 32'd1;
  - `TSI_WORD_W` = 32.
- Single module; no sub-module. Address and counter registers, the write-data register and the read-data register all live in the adapter.

## Test plan
- WRITE, addr 0x8000_0000, len 1, data 0xDEAD_BEEF, 0x1234_5678 → two mem writes to 0x8000_0000 and 0x8000_0004 with that data; `serial_out_valid` never asserts.
- READ, addr 0x8000_0000, len 1, memory returns 0xA, 0xB → `serial_out` delivers 0x0000_000A then 0x0000_000B; then `serial_in_ready` = 1 in S_CMD.
- cmd 0x7 followed by a valid READ header → `bad_cmd` pulses once; the READ then completes normally.
- READ len 3 with `serial_out_ready` and `mem_req_ready` toggled randomly → 4 words, in order, bits stable while stalled.
- addr_hi = 0x1, addr_lo = 0xFFFF_FFFD, MEM_ADDR_W = 32, WRITE len 1 → requests to 0xFFFF_FFFC, then 0x0000_0000.
- Reset asserted during S_WRESP of beat 0 of a 4-beat write → all outputs return to reset values; the next cmd word is accepted as a new command.
